cart_bus_arb: RTL

Parametrised N-channel arbiter that owns the single cart_iface transaction port (rd/wr/addr/data/busy) on the clk_8m domain. It replaces the static priority mux that hands the cart bus from the startup-screen reader, the splash reader and the SPI cart bridge. Ownership is decided per transaction, with fixed-priority or round-robin selection, a per-channel retire mask, completion acknowledge and a busy-timeout guard. All clients share one registered read-data bus.

---
 rtl/cart_bus_arb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cart_bus_arb.sv
// cart_bus_arb
//   Owns the single cart_iface transaction port on the clk_8m domain and hands it
//   to one of NCH requesting channels per transaction. Selection is fixed
//   priority (lowest index wins) or round-robin. Channels can be retired
//   permanently. A timeout guard aborts a transaction whose cart_busy never rises.
//
// Ports
//   clk_8m, rst_n        clock, asynchronous active-low reset
//   req_rd/req_wr        per-channel read/write request levels, held until ack
//   req_a/req_din        per-channel address/write data, channel i at [i*W +: W]
//   retire               per-channel retire pulse, sticky until reset
//   req_ack/req_err      completion pulse to owner, error flag on timeout
//   rsp_data             read data of the last completed read
//   grant                one-hot current owner, 0 when idle
//   cart_rd/cart_wr      one-cycle strobes to cart_iface
//   cart_a/cart_din      registered address/write data to cart_iface
//   cart_dout/cart_busy  read data and busy from cart_iface
module cart_bus_arb #(
   parameter int NCH = 3,
   parameter int AW  = 16,
   parameter int DW  = 8,
   parameter int RR  = 0,
   parameter int TMO = 8
) (
   input  logic              clk_8m,
   input  logic              rst_n,
   input  logic [NCH-1:0]    req_rd,
   input  logic [NCH-1:0]    req_wr,
   input  logic [NCH*AW-1:0] req_a,
   input  logic [NCH*DW-1:0] req_din,
   input  logic [NCH-1:0]    retire,
   output logic [NCH-1:0]    req_ack,
   output logic              req_err,
   output logic [DW-1:0]     rsp_data,
   output logic [NCH-1:0]    grant,
   output logic              cart_rd,
   output logic              cart_wr,
   output logic [AW-1:0]     cart_a,
   output logic [DW-1:0]     cart_din,
   input  logic [DW-1:0]     cart_dout,
   input  logic              cart_busy
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_ACK
   } state_t;

   state_t         state;
   logic [NCH-1:0] retired;
   logic [IW-1:0]  last;
   logic [IW-1:0]  own;
   logic           is_wr;
   logic           err;
   logic [7:0]     cnt;

   logic [NCH-1:0] ereq;
   logic           win_found;
   logic [IW-1:0]  win_idx;

   assign ereq = (req_rd | req_wr) & ~retired;

   // Winner search: scan order starts at 0 for fixed priority, or just past the
   // previous owner for round-robin, wrapping modulo NCH.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NCH; k++) begin
         if (RR != 0) idx = (int'(last) + 1 + k) % NCH;
         else         idx = k;
         if (!win_found && ereq[idx]) begin
            win_found = 1'b1;
            win_idx   = IW'(idx);
         end
      end
   end

   always_ff @(posedge clk_8m or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         retired  <= '0;
         last     <= IW'(NCH - 1);
         own      <= '0;
         is_wr    <= 1'b0;
         err      <= 1'b0;
         cnt      <= '0;
         req_ack  <= '0;
         req_err  <= 1'b0;
         rsp_data <= '0;
         grant    <= '0;
         cart_rd  <= 1'b0;
         cart_wr  <= 1'b0;
         cart_a   <= '0;
         cart_din <= '0;
      end else begin
         retired <= retired | retire;
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  own      <= win_idx;
                  grant    <= NCH'(1) << win_idx;
                  cart_a   <= req_a[win_idx*AW +: AW];
                  cart_din <= req_din[win_idx*DW +: DW];
                  // A simultaneous read and write request resolves to the write.
                  is_wr    <= req_wr[win_idx];
                  cart_wr  <= req_wr[win_idx];
                  cart_rd  <= ~req_wr[win_idx];
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cart_rd <= 1'b0;
               cart_wr <= 1'b0;
               cnt     <= '0;
               state   <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (cart_busy) begin
                  state <= S_WAIT_DONE;
               end else if (cnt == 8'(TMO - 1)) begin
                  // cnt+1 reaches TMO this cycle: abort without capturing data.
                  err     <= 1'b1;
                  req_ack <= NCH'(1) << own;
                  req_err <= 1'b1;
                  state   <= S_ACK;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_WAIT_DONE: begin
               if (!cart_busy) begin
                  if (!is_wr) rsp_data <= cart_dout;
                  req_ack <= NCH'(1) << own;
                  req_err <= err;
                  state   <= S_ACK;
               end
            end
            S_ACK: begin
               req_ack <= '0;
               req_err <= 1'b0;
               grant   <= '0;
               err     <= 1'b0;
               last    <= own;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
